// File: rtl/numbo_pkg.sv
// Shared types and defaults for the numbotron register bank.
package numbo_pkg;

  localparam int NREGS_DEF = 8;
  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    OP_HOLD,
    OP_INC,
    OP_DEC
  } op_t;

  // Opposing masks on the same register cancel.
  function automatic op_t op_of(input logic inc, input logic dec);
    op_t op;
    op = OP_HOLD;
    if (inc && !dec) op = OP_INC;
    else if (dec && !inc) op = OP_DEC;
    return op;
  endfunction

endpackage

// File: rtl/numbo_counter.sv
// One register cell: sequencer op, preset, and UI edit with wrap/floor handling.
module numbo_counter
  import numbo_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rstb,
  input  op_t              op,
  input  logic             preset,
  input  logic [WIDTH-1:0] preset_val,
  input  logic             clr,
  input  logic             edit_inc,
  output logic [WIDTH-1:0] value,
  output logic             zero,
  output logic             ovf,
  output logic             unf
);

  logic [WIDTH-1:0] next_value;

  // Caller guarantees op is OP_HOLD whenever a UI edit is allowed.
  always_comb begin
    next_value = value;
    ovf        = 1'b0;
    unf        = 1'b0;
    if (preset) begin
      next_value = preset_val;
    end else if (op == OP_INC) begin
      next_value = value + WIDTH'(1);
      ovf        = (value == '1);
    end else if (op == OP_DEC) begin
      if (value != '0) next_value = value - WIDTH'(1);
      else             unf        = 1'b1;
    end else if (clr) begin
      next_value = '0;
    end else if (edit_inc) begin
      next_value = value + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) value <= RST_VAL;
    else       value <= next_value;
  end

  assign zero = (value == '0);

endmodule

// File: rtl/numbo_regfile.sv
// Register bank for the numbotron sequencer: step edge detect, counters, sticky flags, UI view/edit.
module numbo_regfile
  import numbo_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter logic [WIDTH-1:0] INIT0 = {{(WIDTH-1){1'b0}}, 1'b1},
  parameter logic [WIDTH-1:0] INIT1 = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic [NREGS-1:0] inc_regs,
  input  logic [NREGS-1:0] dec_regs,
  input  logic             dostep,
  input  logic             running,
  input  logic             load_init,
  input  logic [2:0]       ui_sel,
  input  logic             ui_inc,
  input  logic             ui_clr,
  output logic [NREGS-1:0] reg_0,
  output logic [WIDTH-1:0] ui_val,
  output logic [15:0]      step_count,
  output logic [NREGS-1:0] ovf_flags,
  output logic [NREGS-1:0] unf_flags
);

  logic             dostep_q;
  logic             fire;
  logic             edit_ok;
  logic [NREGS-1:0] ovf_p;
  logic [NREGS-1:0] unf_p;
  logic [WIDTH-1:0] vals [NREGS];

  assign fire    = dostep && !dostep_q;
  assign edit_ok = !running && !fire && !load_init;

  for (genvar i = 0; i < NREGS; i++) begin : g_cell
    localparam logic [WIDTH-1:0] IV = (i == 0) ? INIT0 : (i == 1) ? INIT1 : '0;
    logic hit;
    op_t  op;

    assign hit = edit_ok && (32'(ui_sel) == i);
    assign op  = fire ? op_of(inc_regs[i], dec_regs[i]) : OP_HOLD;

    numbo_counter #(
      .WIDTH   (WIDTH),
      .RST_VAL (IV)
    ) u_cell (
      .clk        (clk),
      .rstb       (rstb),
      .op         (op),
      .preset     (load_init),
      .preset_val (IV),
      .clr        (hit && ui_clr),
      .edit_inc   (hit && ui_inc),
      .value      (vals[i]),
      .zero       (reg_0[i]),
      .ovf        (ovf_p[i]),
      .unf        (unf_p[i])
    );
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      dostep_q   <= 1'b0;
      step_count <= '0;
      ovf_flags  <= '0;
      unf_flags  <= '0;
    end else begin
      dostep_q <= dostep;
      if (load_init) begin
        step_count <= '0;
        ovf_flags  <= '0;
        unf_flags  <= '0;
      end else begin
        if (fire) step_count <= step_count + 16'd1;
        ovf_flags <= ovf_flags | ovf_p;
        unf_flags <= unf_flags | unf_p;
      end
    end
  end

  always_comb begin
    ui_val = '0;
    if (32'(ui_sel) < NREGS) ui_val = vals[ui_sel];
  end

endmodule

// File: tb/tb_numbo_regfile.sv
// Directed bench for numbo_regfile: step vector table plus multi-cycle edit/overflow/reset sequences.
module tb_numbo_regfile;

  logic       clk = 1'b0;
  logic       rstb;
  logic [7:0] inc_regs, dec_regs;
  logic       dostep, running, load_init;
  logic [2:0] ui_sel;
  logic       ui_inc, ui_clr;
  logic [7:0] reg_0, ui_val, ovf_flags, unf_flags;
  logic [15:0] step_count;

  int n_cmp = 0;
  int n_bad = 0;

  numbo_regfile #(.NREGS(8), .WIDTH(8), .INIT0(8'h01), .INIT1(8'h01)) dut (
    .clk        (clk),
    .rstb       (rstb),
    .inc_regs   (inc_regs),
    .dec_regs   (dec_regs),
    .dostep     (dostep),
    .running    (running),
    .load_init  (load_init),
    .ui_sel     (ui_sel),
    .ui_inc     (ui_inc),
    .ui_clr     (ui_clr),
    .reg_0      (reg_0),
    .ui_val     (ui_val),
    .step_count (step_count),
    .ovf_flags  (ovf_flags),
    .unf_flags  (unf_flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  inc;
    logic [7:0]  dec;
    logic [2:0]  sel;
    logic [7:0]  exp_z;
    logic [7:0]  exp_val;
    logic [15:0] exp_step;
    logic [7:0]  exp_ovf;
    logic [7:0]  exp_unf;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Single-cycle dostep pulse driven from a negedge; fires on the following posedge.
  task automatic pulse(input logic [7:0] inc, input logic [7:0] dec);
    @(negedge clk);
    inc_regs = inc;
    dec_regs = dec;
    dostep   = 1'b1;
    @(negedge clk);
    dostep   = 1'b0;
  endtask

  initial begin
    // from reset: r0=1 r1=1 others 0
    vecs[0] = '{8'h02, 8'h00, 3'd1, 8'hFC, 8'h02, 16'd1, 8'h00, 8'h00};
    vecs[1] = '{8'h00, 8'h01, 3'd0, 8'hFD, 8'h00, 16'd2, 8'h00, 8'h00};
    vecs[2] = '{8'h00, 8'h01, 3'd0, 8'hFD, 8'h00, 16'd3, 8'h00, 8'h01};
    vecs[3] = '{8'hF0, 8'h00, 3'd4, 8'h0D, 8'h01, 16'd4, 8'h00, 8'h01};
    vecs[4] = '{8'h11, 8'h11, 3'd4, 8'h0D, 8'h01, 16'd5, 8'h00, 8'h01};
    vecs[5] = '{8'h00, 8'h00, 3'd1, 8'h0D, 8'h02, 16'd6, 8'h00, 8'h01};
    vecs[6] = '{8'h01, 8'hF2, 3'd1, 8'hFC, 8'h01, 16'd7, 8'h00, 8'h01};
    vecs[7] = '{8'h00, 8'h80, 3'd7, 8'hFC, 8'h00, 16'd8, 8'h00, 8'h81};

    rstb = 1'b0; inc_regs = '0; dec_regs = '0; dostep = 1'b0;
    running = 1'b0; load_init = 1'b0; ui_sel = 3'd0; ui_inc = 1'b0; ui_clr = 1'b0;
    repeat (2) @(negedge clk);
    rstb = 1'b1;
    @(negedge clk);
    chk("reset reg_0", reg_0, 8'hFC);
    chk("reset ui_val", ui_val, 8'h01);
    chk("reset step_count", step_count, 16'd0);
    chk("reset ovf", ovf_flags, 8'h00);
    chk("reset unf", unf_flags, 8'h00);

    for (int i = 0; i < 8; i++) begin
      ui_sel = vecs[i].sel;
      pulse(vecs[i].inc, vecs[i].dec);
      chk($sformatf("vec%0d reg_0", i), reg_0, vecs[i].exp_z);
      chk($sformatf("vec%0d ui_val", i), ui_val, vecs[i].exp_val);
      chk($sformatf("vec%0d step", i), step_count, vecs[i].exp_step);
      chk($sformatf("vec%0d ovf", i), ovf_flags, vecs[i].exp_ovf);
      chk($sformatf("vec%0d unf", i), unf_flags, vecs[i].exp_unf);
    end

    // dostep held 5 clocks gives one op: r1 1 -> 2
    ui_sel = 3'd1;
    @(negedge clk);
    inc_regs = 8'h02; dec_regs = 8'h00; dostep = 1'b1;
    repeat (5) @(negedge clk);
    dostep = 1'b0;
    @(negedge clk);
    chk("long dostep r1", ui_val, 8'h02);
    chk("long dostep step", step_count, 16'd9);

    // UI increments r3 to FF (no ovf flag), then a sequencer inc wraps it
    ui_sel = 3'd3; ui_inc = 1'b1;
    repeat (255) @(negedge clk);
    ui_inc = 1'b0;
    chk("ui_inc r3", ui_val, 8'hFF);
    chk("ui_inc no ovf", ovf_flags, 8'h00);
    @(negedge clk);
    inc_regs = 8'h08; dec_regs = 8'h00; dostep = 1'b1;
    chk("pre-fire reg_0[3]", reg_0[3], 1'b0);
    @(negedge clk);
    dostep = 1'b0;
    chk("wrap r3", ui_val, 8'h00);
    chk("wrap reg_0[3]", reg_0[3], 1'b1);
    chk("wrap ovf", ovf_flags, 8'h08);
    chk("wrap step", step_count, 16'd10);

    // UI clear in the same cycle as a fire is ignored
    ui_sel = 3'd1;
    @(negedge clk);
    inc_regs = 8'h00; dostep = 1'b1; ui_clr = 1'b1;
    @(negedge clk);
    dostep = 1'b0; ui_clr = 1'b0;
    chk("fire blocks clr", ui_val, 8'h02);
    chk("fire blocks clr step", step_count, 16'd11);

    // running blocks edits; clr wins over inc when idle
    running = 1'b1; ui_clr = 1'b1;
    @(negedge clk);
    chk("running blocks clr", ui_val, 8'h02);
    running = 1'b0; ui_inc = 1'b1;
    @(negedge clk);
    ui_clr = 1'b0; ui_inc = 1'b0;
    chk("clr wins", ui_val, 8'h00);
    chk("clr reg_0", reg_0, 8'hFE);

    // load_init coincident with a dostep edge: preset wins, step_count cleared
    inc_regs = 8'hFF; dostep = 1'b1; load_init = 1'b1;
    @(negedge clk);
    load_init = 1'b0; dostep = 1'b0;
    chk("load reg_0", reg_0, 8'hFC);
    chk("load r1", ui_val, 8'h01);
    chk("load step", step_count, 16'd0);
    chk("load ovf", ovf_flags, 8'h00);
    chk("load unf", unf_flags, 8'h00);

    // reset mid-dostep: immediate preset, no op until a fresh edge
    ui_sel = 3'd2;
    pulse(8'h04, 8'h00);
    chk("pre-reset r2", ui_val, 8'h01);
    dostep = 1'b1;
    #2;
    rstb = 1'b0;
    #1;
    chk("async reset reg_0", reg_0, 8'hFC);
    chk("async reset r2", ui_val, 8'h00);
    @(negedge clk);
    dostep = 1'b0;
    @(negedge clk);
    rstb = 1'b1;
    repeat (2) @(negedge clk);
    chk("post-reset r2", ui_val, 8'h00);
    chk("post-reset step", step_count, 16'd0);
    pulse(8'h04, 8'h00);
    chk("new edge r2", ui_val, 8'h01);
    chk("new edge step", step_count, 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
